// File: rtl/oam_dma_if.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma_if
// Description : CPU-bus bundle between the CPU side and the sprite DMA engine.
//               master = CPU/bus side, slave = DMA engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface oam_dma_if;
    logic        ce;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_d;
    logic        cpu_w;
    logic        cpu_m0;
    logic [7:0]  mem_i;
    logic        cpu_ce;
    logic        busy;
    logic [15:0] A;
    logic [7:0]  D;
    logic        R;
    logic        W;

    modport master (
        output ce, cpu_a, cpu_d, cpu_w, cpu_m0, mem_i,
        input  cpu_ce, busy, A, D, R, W
    );

    modport slave (
        input  ce, cpu_a, cpu_d, cpu_w, cpu_m0, mem_i,
        output cpu_ce, busy, A, D, R, W
    );
endinterface
`default_nettype wire

// File: rtl/oam_dma.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma
// Description : Sprite DMA. Captures a CPU write to DMA_REG, stalls the CPU at
//               its next opcode fetch, copies page $XX00-$XXFF to OAM_REG and
//               releases the CPU. Owns the bus address/strobes while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module oam_dma #(
    parameter logic [15:0] DMA_REG = 16'h4014,
    parameter logic [15:0] OAM_REG = 16'h2004
) (
    input wire       clock,
    input wire       reset_n,
    oam_dma_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PEND  = 3'd1,
        S_HALT  = 3'd2,
        S_ALIGN = 3'd3,
        S_READ  = 3'd4,
        S_WRITE = 3'd5
    } state_t;

    state_t      r_state, w_state_next;
    logic        r_odd;
    logic [7:0]  r_page, w_page_next;
    logic [7:0]  r_idx,  w_idx_next;
    logic [7:0]  r_tr,   w_tr_next;
    logic [15:0] r_addr, w_addr_next;
    logic        r_rd,   w_rd_next;
    logic        r_wr,   w_wr_next;
    logic [7:0]  w_idx_inc;
    logic        w_busy;

    assign w_idx_inc = r_idx + 8'd1;
    assign w_busy    = (r_state != S_IDLE) && (r_state != S_PEND);

    // The CPU is frozen while DMA owns the bus and also on the very fetch
    // cycle that starts the halt, so that fetch is replayed after release.
    assign bus.cpu_ce = bus.ce & ~w_busy & ~((r_state == S_PEND) & bus.cpu_m0);
    assign bus.busy   = w_busy;
    assign bus.A      = r_addr;
    assign bus.D      = r_tr;
    assign bus.R      = r_rd;
    assign bus.W      = r_wr;

    // Free-running CPU-cycle parity, used to align the first read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)    r_odd <= 1'b0;
        else if (bus.ce) r_odd <= ~r_odd;
    end

    // State and registered bus outputs; next values already hold when ce=0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_page  <= 8'h00;
            r_idx   <= 8'h00;
            r_tr    <= 8'h00;
            r_addr  <= 16'h0000;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_page  <= w_page_next;
            r_idx   <= w_idx_next;
            r_tr    <= w_tr_next;
            r_addr  <= w_addr_next;
            r_rd    <= w_rd_next;
            r_wr    <= w_wr_next;
        end
    end

    // Next-state and next-output decode; outputs change on the edge entering a state.
    always_comb begin
        w_state_next = r_state;
        w_page_next  = r_page;
        w_idx_next   = r_idx;
        w_tr_next    = r_tr;
        w_addr_next  = r_addr;
        w_rd_next    = r_rd;
        w_wr_next    = r_wr;
        if (bus.ce) begin
            case (r_state)
                S_IDLE: begin
                    w_rd_next = 1'b0;
                    w_wr_next = 1'b0;
                    if (bus.cpu_w && (bus.cpu_a == DMA_REG)) begin
                        w_page_next  = bus.cpu_d;
                        w_idx_next   = 8'h00;
                        w_state_next = S_PEND;
                    end
                end
                S_PEND: begin
                    if (bus.cpu_m0) w_state_next = S_HALT;
                end
                S_HALT: begin
                    if (r_odd) begin
                        w_state_next = S_ALIGN;
                    end else begin
                        w_state_next = S_READ;
                        w_addr_next  = {r_page, r_idx};
                        w_rd_next    = 1'b1;
                        w_wr_next    = 1'b0;
                    end
                end
                S_ALIGN: begin
                    w_state_next = S_READ;
                    w_addr_next  = {r_page, r_idx};
                    w_rd_next    = 1'b1;
                    w_wr_next    = 1'b0;
                end
                S_READ: begin
                    w_tr_next    = bus.mem_i;
                    w_state_next = S_WRITE;
                    w_addr_next  = OAM_REG;
                    w_rd_next    = 1'b0;
                    w_wr_next    = 1'b1;
                end
                S_WRITE: begin
                    w_idx_next = w_idx_inc;
                    w_wr_next  = 1'b0;
                    if (r_idx == 8'hFF) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_READ;
                        w_addr_next  = {r_page, w_idx_inc};
                        w_rd_next    = 1'b1;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_rd_next    = 1'b0;
                    w_wr_next    = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
